cam_match_seq: RTL
==================

CAM_MATCH_SEQ -- requirements
Module: cam_match_seq

Interface
REQ-001 Parameter CAM_LEN, default 256, SHALL set the CAM match-vector width.
REQ-002 Parameter IDX_W, default 8, SHALL equal $clog2(CAM_LEN).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 in_valid  input  1  SHALL flag that a new match vector is offered.
REQ-006 in_ready  output  1  SHALL flag that the block accepts a new vector.
REQ-007 in_vector  input  CAM_LEN  SHALL carry the raw CAM match vector.
REQ-008 flush  input  1  SHALL abort the current scan.
REQ-009 out_valid  output  1  SHALL flag that a selected match is presented.
REQ-010 out_ready  input  1  SHALL flag that the consumer takes the selected match.
REQ-011 out_onehot  output  CAM_LEN  SHALL carry the one-hot selected match line.
REQ-012 out_index  output  IDX_W  SHALL carry the binary index of the selected line.
REQ-013 out_seq  output  IDX_W+1  SHALL carry the 0-based ordinal of the emission within the current vector.
REQ-014 out_last  output  1  SHALL flag the final match of the current vector.
REQ-015 empty_pulse  output  1  SHALL flag, for one cycle, that an accepted vector had no set bits.

Function
REQ-016 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-017 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 An in_valid&&in_ready cycle SHALL register in_vector into the residue register; if the vector is nonzero, the next state SHALL be SCAN.
REQ-019 An accepted all-zero vector SHALL keep the FSM in IDLE and assert empty_pulse for exactly the following cycle.
REQ-020 In SCAN, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-021 out_onehot SHALL equal the highest-index set bit of the residue; the first match SHALL appear the cycle after acceptance (latency 1).
REQ-022 out_index SHALL equal the bit position in out_onehot.
REQ-023 out_last SHALL be 1 when the residue has exactly one set bit.
REQ-024 While out_valid&&!out_ready, all out_* signals SHALL hold stable.
REQ-025 On out_valid&&out_ready, the selected bit SHALL be cleared from the residue and out_seq SHALL increment.
REQ-026 A handshake with out_last=1 SHALL return the FSM to IDLE and zero out_seq; in_ready SHALL reassert on the next cycle, with no same-cycle re-accept.
REQ-027 flush SHALL, in any state, clear the residue and out_seq and force IDLE the next cycle.
REQ-028 flush SHALL take priority over a simultaneous output handshake or input acceptance; no empty_pulse SHALL result.
REQ-029 A CAM_LEN-bit all-ones vector SHALL yield CAM_LEN emissions, out_seq 0..CAM_LEN-1; the IDX_W+1 width SHALL prevent wrap.

Reset
REQ-030 rst SHALL force IDLE, residue 0, out_seq 0, out_valid 0, out_onehot 0, out_index 0, out_last 0 and empty_pulse 0.
REQ-031 in_ready SHALL be 0 while rst is high and SHALL be 1 the first cycle after release.
REQ-032 rst asserted mid-SCAN SHALL discard the remaining matches without further emissions.

Structure
REQ-033 The shared package SHALL hold CAM_LEN, IDX_W and the FSM state enum (IDLE, SCAN).
REQ-034 Highest-set-bit selection SHALL be a sub-module, cam_prio_pick.
- Input: a CAM_LEN vector.
- Outputs: a one-hot vector, a binary index and an any flag.
- It SHALL be purely combinational, built as a log-depth halving tree.

Verification
REQ-035 Input 256'h0...0_8001 -> out_index 15 (seq 0, last 0), then out_index 0 (seq 1, last 1); in_ready high the cycle after the second handshake.
REQ-036 Input with bits 255, 128 and 3 set, out_ready low for 5 cycles -> outputs hold index 255 throughout; then indices 255, 128, 3 in order on consecutive cycles.
REQ-037 Input 0 -> empty_pulse high for 1 cycle, out_valid never high, in_ready stays 1.
REQ-038 All-ones input with out_ready held 1 -> 256 emissions, indices 255 down to 0, out_seq 0 to 255, out_last only on index 0.
REQ-039 flush asserted together with a handshake at seq 2 of a 5-bit vector -> IDLE next cycle, no further out_valid, next vector starts at seq 0.
REQ-040 rst asserted mid-SCAN -> all outputs 0 the next cycle; in_ready is 1 the cycle after rst drops.

Source files
------------

// File: rtl/cam_match_seq_pkg.sv
// Shared definitions for the CAM match sequencer.
//   CAM_LEN : width of the CAM match vector
//   IDX_W   : width of a binary line index, $clog2(CAM_LEN)
//   state_e : sequencer FSM states
package cam_match_seq_pkg;

  localparam int unsigned CAM_LEN = 256;
  localparam int unsigned IDX_W   = $clog2(CAM_LEN);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage

// File: rtl/cam_match_seq_if.sv
// Handshake bundle of the CAM match sequencer.
//   in_valid/in_ready/in_vector : match-vector input channel
//   flush                       : abort the current scan
//   out_valid/out_ready         : selected-match output channel
//   out_onehot/out_index        : selected line, one-hot and binary
//   out_seq/out_last            : ordinal of the emission, final-match flag
//   empty_pulse                 : an accepted vector had no set bits
// Modport master is the producer/consumer side, slave is the sequencer.
interface cam_match_seq_if #(
  parameter int unsigned CAM_LEN = cam_match_seq_pkg::CAM_LEN,
  parameter int unsigned IDX_W   = cam_match_seq_pkg::IDX_W
);

  logic               in_valid;
  logic               in_ready;
  logic [CAM_LEN-1:0] in_vector;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [CAM_LEN-1:0] out_onehot;
  logic [IDX_W-1:0]   out_index;
  logic [IDX_W:0]     out_seq;
  logic               out_last;
  logic               empty_pulse;

  modport master (
    output in_valid, in_vector, flush, out_ready,
    input  in_ready, out_valid, out_onehot, out_index, out_seq, out_last, empty_pulse
  );

  modport slave (
    input  in_valid, in_vector, flush, out_ready,
    output in_ready, out_valid, out_onehot, out_index, out_seq, out_last, empty_pulse
  );

endinterface

// File: rtl/cam_prio_pick.sv
// Combinational highest-set-bit picker.
//   i_vec    : input vector
//   o_onehot : one-hot of the highest set bit (0 when none)
//   o_index  : binary position of that bit (0 when none)
//   o_any    : at least one bit is set
// CAM_LEN must be a power of two.
module cam_prio_pick #(
  parameter int unsigned CAM_LEN = cam_match_seq_pkg::CAM_LEN,
  parameter int unsigned IDX_W   = cam_match_seq_pkg::IDX_W
) (
  input  logic [CAM_LEN-1:0] i_vec,
  output logic [CAM_LEN-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any
);

  // Halving tree: each level merges node pairs, the upper child wins when it has a hit
  // and contributes the next index bit. Nodes are updated in place; node n only reads
  // nodes 2n and 2n+1, which are never already overwritten on the same level.
  function automatic logic [IDX_W:0] pick_top(input logic [CAM_LEN-1:0] vec);
    logic             any_t [CAM_LEN];
    logic [IDX_W-1:0] idx_t [CAM_LEN];
    for (int n = 0; n < int'(CAM_LEN); n++) begin
      any_t[n] = vec[n];
      idx_t[n] = '0;
    end
    for (int lv = 0; lv < int'(IDX_W); lv++) begin
      for (int n = 0; n < int'(CAM_LEN >> (lv + 1)); n++) begin
        if (any_t[2*n+1]) idx_t[n] = idx_t[2*n+1] | (IDX_W'(1) << lv);
        else              idx_t[n] = idx_t[2*n];
        any_t[n] = any_t[2*n+1] | any_t[2*n];
      end
    end
    return {any_t[0], idx_t[0]};
  endfunction

  logic [IDX_W:0] w_pick;

  always_comb begin
    w_pick   = pick_top(i_vec);
    o_any    = w_pick[IDX_W];
    o_index  = w_pick[IDX_W-1:0];
    o_onehot = '0;
    o_onehot[w_pick[IDX_W-1:0]] = w_pick[IDX_W];
  end

endmodule

// File: rtl/cam_match_seq.sv
// CAM match sequencer: accepts a raw match vector and emits its set bits one at a time,
// highest index first, with index, ordinal and last-match flag.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : cam_match_seq_if slave (input vector channel, output match channel, flush,
//         empty_pulse)
module cam_match_seq #(
  parameter int unsigned CAM_LEN = cam_match_seq_pkg::CAM_LEN,
  parameter int unsigned IDX_W   = cam_match_seq_pkg::IDX_W
) (
  input logic           clk,
  input logic           rst,
  cam_match_seq_if.slave bus
);

  import cam_match_seq_pkg::*;

  state_e             r_state, w_state_d;
  logic [CAM_LEN-1:0] r_residue, w_residue_d;
  logic [IDX_W:0]     r_seq, w_seq_d;
  logic               r_empty, w_empty_d;

  logic [CAM_LEN-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_index;
  logic               w_pick_any;
  logic               w_scan;
  logic               w_single;

  cam_prio_pick #(
    .CAM_LEN (CAM_LEN),
    .IDX_W   (IDX_W)
  ) u_pick (
    .i_vec    (r_residue),
    .o_onehot (w_pick_onehot),
    .o_index  (w_pick_index),
    .o_any    (w_pick_any)
  );

  assign w_scan   = (r_state == SCAN);
  // Residue equals its own top bit only when exactly one bit is set.
  assign w_single = w_pick_any && (r_residue == w_pick_onehot);

  assign bus.in_ready    = (r_state == IDLE) && !rst;
  assign bus.out_valid   = w_scan;
  assign bus.out_onehot  = w_scan ? w_pick_onehot : '0;
  assign bus.out_index   = w_scan ? w_pick_index : '0;
  assign bus.out_last    = w_scan && w_single;
  assign bus.out_seq     = r_seq;
  assign bus.empty_pulse = r_empty;

  always_comb begin
    w_state_d   = r_state;
    w_residue_d = r_residue;
    w_seq_d     = r_seq;
    w_empty_d   = 1'b0;
    if (bus.flush) begin
      w_state_d   = IDLE;
      w_residue_d = '0;
      w_seq_d     = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_residue_d = bus.in_vector;
            if (|bus.in_vector) w_state_d = SCAN;
            else                w_empty_d = 1'b1;
          end
        end
        SCAN: begin
          if (bus.out_ready) begin
            w_residue_d = r_residue & ~w_pick_onehot;
            if (w_single) begin
              w_state_d = IDLE;
              w_seq_d   = '0;
            end else begin
              w_seq_d = r_seq + (IDX_W+1)'(1);
            end
          end
        end
        default: w_state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_residue <= '0;
      r_seq     <= '0;
      r_empty   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_residue <= w_residue_d;
      r_seq     <= w_seq_d;
      r_empty   <= w_empty_d;
    end
  end

endmodule
